// File: rtl/dbf_fine_apod.sv
// Beamformer per-channel fine delay (two-tap linear interpolation) and apodization.
// Define FINE_DELAY_EN to build the fraction LUT; otherwise every fraction is 0.
module dbf_fine_apod #(
  parameter int INPUT_WD    = 14,
  parameter int FRAC_WD     = 4,
  parameter int APO_WD      = 16,
  parameter int ADDR_WD     = 12,
  parameter int NUM_SAMPLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [INPUT_WD-1:0] fd_din,
  input  logic                       fd_din_valid,
  input  logic signed [APO_WD-1:0]   apo_din,
  input  logic [ADDR_WD-1:0]         lut_addr,
  input  logic [FRAC_WD-1:0]         lut_din,
  input  logic                       lut_we,
  output logic signed [31:0]         dbf_dout,
  output logic                       dbf_dout_valid,
  output logic                       line_done
);

  localparam int FD_WD   = INPUT_WD + FRAC_WD;
  localparam int PROD_WD = FD_WD + APO_WD;
  localparam logic [ADDR_WD-1:0] LAST_IDX = ADDR_WD'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     r_state;
  logic                       r_start_d;
  logic [ADDR_WD-1:0]         r_sample_cnt;
  logic signed [INPUT_WD-1:0] r_x_cur;
  logic signed [INPUT_WD-1:0] r_x_prev;
  logic signed [APO_WD-1:0]   r_apo1;
  logic signed [APO_WD-1:0]   r_apo2;
  logic signed [FD_WD-1:0]    r_fd;
  logic                       r_v1;
  logic                       r_v2;
  logic                       r_last1;
  logic                       r_last2;
  logic signed [31:0]         r_dout;
  logic                       r_dout_valid;
  logic                       r_line_done;

  logic                       w_accept;
  logic                       w_rise;
  logic [FRAC_WD-1:0]         w_frac;
  logic [FD_WD-1:0]           w_wcur;
  logic [FD_WD-1:0]           w_wprev;
  logic signed [FD_WD-1:0]    w_xc_ext;
  logic signed [FD_WD-1:0]    w_xp_ext;
  logic signed [FD_WD-1:0]    w_fd;
  logic signed [PROD_WD-1:0]  w_fd_ext;
  logic signed [PROD_WD-1:0]  w_apo_ext;
  logic signed [PROD_WD-1:0]  w_prod;

  // start must still be high for a sample to count, so an abort beats the last valid.
  assign w_accept = (r_state == RUN) && start && fd_din_valid;
  assign w_rise   = start && !r_start_d;

`ifdef FINE_DELAY_EN
  logic [FRAC_WD-1:0] r_lut [0:(2**ADDR_WD)-1];
  logic [FRAC_WD-1:0] r_frac;

  // Writes and reads never overlap: writes only outside RUN, reads only on accept.
  always_ff @(posedge clk) begin
    if (lut_we && (r_state != RUN))
      r_lut[lut_addr] <= lut_din;
    if (w_accept)
      r_frac <= r_lut[r_sample_cnt];
  end

  assign w_frac = r_frac;
`else
  logic w_lut_unused;
  assign w_lut_unused = ^{lut_addr, lut_din, lut_we};
  assign w_frac       = '0;
`endif

  assign w_wprev  = FD_WD'(w_frac);
  assign w_wcur   = FD_WD'(2**FRAC_WD) - w_wprev;
  assign w_xc_ext = {{FRAC_WD{r_x_cur[INPUT_WD-1]}}, r_x_cur};
  assign w_xp_ext = {{FRAC_WD{r_x_prev[INPUT_WD-1]}}, r_x_prev};
  assign w_fd     = w_xc_ext * $signed(w_wcur) + w_xp_ext * $signed(w_wprev);

  assign w_fd_ext  = {{APO_WD{r_fd[FD_WD-1]}}, r_fd};
  assign w_apo_ext = {{FD_WD{r_apo2[APO_WD-1]}}, r_apo2};
  assign w_prod    = w_fd_ext * w_apo_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_start_d    <= 1'b0;
      r_sample_cnt <= '0;
      r_x_cur      <= '0;
      r_x_prev     <= '0;
      r_apo1       <= '0;
      r_apo2       <= '0;
      r_fd         <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_last1      <= 1'b0;
      r_last2      <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_start_d    <= start;
      r_v1         <= w_accept;
      r_last1      <= w_accept && (r_sample_cnt == LAST_IDX);
      r_v2         <= r_v1;
      r_last2      <= r_last1;
      r_fd         <= w_fd;
      r_apo2       <= r_apo1;
      r_dout_valid <= r_v2;
      r_line_done  <= r_last2;
      r_dout       <= r_v2 ? 32'(w_prod >>> (PROD_WD - 32)) : '0;
      if (w_accept) begin
        r_x_cur      <= fd_din;
        r_x_prev     <= r_x_cur;
        r_apo1       <= apo_din;
        r_sample_cnt <= r_sample_cnt + ADDR_WD'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state      <= RUN;
            r_sample_cnt <= '0;
            r_x_cur      <= '0;
            r_x_prev     <= '0;
          end
        end
        RUN: begin
          if (!start) begin
            // Abort: drop everything in flight so no partial line reaches the summer.
            r_state      <= IDLE;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_last1      <= 1'b0;
            r_last2      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_line_done  <= 1'b0;
            r_dout       <= '0;
          end else if (fd_din_valid && (r_sample_cnt == LAST_IDX)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!start)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dbf_dout       = r_dout;
  assign dbf_dout_valid = r_dout_valid;
  assign line_done      = r_line_done;

endmodule
